aes_sub_shift: RTL and testbench

//  Iterative SubBytes + ShiftRows stage of the AES encryption round; sits directly upstream of the

---
 rtl/aes_sub_shift_pkg.sv | 52 +++++
 rtl/aes_sbox.sv | 19 +
 rtl/aes_sub_shift.sv | 129 ++++++++++++
 tb/tb_aes_sub_shift.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_sub_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_sub_shift_pkg
// Description : Shared AES definitions: block/byte widths, FSM state
//               encoding, the FIPS-197 byte index helper and the forward
//               S-box table with its lookup function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package aes_sub_shift_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_BYTE_W = 8;
  localparam int AES_NBYTES = AES_BLK_W / AES_BYTE_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } fsm_state_t;

  // Column-major byte numbering of the AES state: row r, column c.
  function automatic int byte_idx(input int r, input int c);
    return r + 4 * c;
  endfunction

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [AES_BYTE_W-1:0] sbox_lookup(input logic [AES_BYTE_W-1:0] b);
    return SBOX_TABLE[2047 - AES_BYTE_W * int'(b) -: AES_BYTE_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box (single byte).
// Ports       : byte_val [7:0] in  - byte to substitute
//               sub_val  [7:0] out - S-box image of byte_val
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_sub_shift_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] byte_val,
  output logic [AES_BYTE_W-1:0] sub_val
);

  assign sub_val = sbox_lookup(byte_val);

endmodule
`default_nettype wire

// File: rtl/aes_sub_shift.sv
`default_nettype none
// ============================================================================
// Module      : aes_sub_shift
// Description : Iterative SubBytes + ShiftRows stage. Accepts one 128-bit
//               state, substitutes BYTES_PER_CYCLE bytes per clock through
//               shared S-boxes, then holds the ShiftRows-permuted result
//               until the consumer takes it.
// Ports       : clk            in   clock, rising edge
//               rst_n          in   synchronous reset, active low
//               state_i[127:0] in   input state (byte k at [127-8k -: 8])
//               valid_i        in   input valid
//               ready_o        out  stage can accept (IDLE)
//               state_o[127:0] out  ShiftRows(SubBytes(state_i))
//               valid_o        out  result valid (DONE)
//               ready_i        in   consumer accepts result
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sub_shift
  import aes_sub_shift_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AES_BLK_W-1:0] state_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [AES_BLK_W-1:0] state_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int NSTEP = AES_NBYTES / BYTES_PER_CYCLE;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

  fsm_state_t             fsm_q, fsm_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_BYTE_W-1:0]  blk_q   [AES_NBYTES];
  logic [AES_BYTE_W-1:0]  blk_d   [AES_NBYTES];
  logic [AES_BYTE_W-1:0]  sub_in  [BYTES_PER_CYCLE];
  logic [AES_BYTE_W-1:0]  sub_out [BYTES_PER_CYCLE];

  // Select the group of bytes addressed by the step counter.
  always_comb begin
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      sub_in[j] = '0;
      for (int s = 0; s < NSTEP; s++) begin
        if (cnt_q == CNT_W'(s)) begin
          sub_in[j] = blk_q[s * BYTES_PER_CYCLE + j];
        end
      end
    end
  end

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_val (sub_in[j]),
      .sub_val  (sub_out[j])
    );
  end

  // Next-state, per-byte write enables and handshake outputs.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          for (int k = 0; k < AES_NBYTES; k++) begin
            blk_d[k] = state_i[AES_BLK_W-1-AES_BYTE_W*k -: AES_BYTE_W];
          end
          cnt_d = '0;
          fsm_d = S_SUB;
        end
      end
      S_SUB: begin
        for (int s = 0; s < NSTEP; s++) begin
          if (cnt_q == CNT_W'(s)) begin
            for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
              blk_d[s * BYTES_PER_CYCLE + j] = sub_out[j];
            end
          end
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          fsm_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      cnt_q <= '0;
      for (int k = 0; k < AES_NBYTES; k++) begin
        blk_q[k] <= '0;
      end
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

  // ShiftRows: row r rotates left by r columns; pure wiring off the register.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign state_o[AES_BLK_W-1-AES_BYTE_W*byte_idx(r, c) -: AES_BYTE_W] =
        blk_q[byte_idx(r, (c + r) % 4)];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_shift.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_sub_shift
// Description : Directed self-checking bench for aes_sub_shift. One main
//               instance (4 bytes/cycle) plus a sweep of instances with
//               1, 2, 4, 8 and 16 bytes/cycle sharing clock and reset.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_sub_shift;

  localparam int NSW = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] state_i, state_o;
  logic         valid_i, ready_o, valid_o, ready_i;

  logic [127:0] sw_state_i [NSW];
  logic [127:0] sw_state_o [NSW];
  logic         sw_valid_i [NSW];
  logic         sw_ready_o [NSW];
  logic         sw_valid_o [NSW];
  logic         sw_ready_i [NSW];

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  always #5 clk = ~clk;

  aes_sub_shift #(.BYTES_PER_CYCLE(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_i (state_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .state_o (state_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  for (genvar g = 0; g < NSW; g++) begin : g_sweep
    aes_sub_shift #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .state_i (sw_state_i[g]),
      .valid_i (sw_valid_i[g]),
      .ready_o (sw_ready_o[g]),
      .state_o (sw_state_o[g]),
      .valid_o (sw_valid_o[g]),
      .ready_i (sw_ready_i[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r1_in, r1_out, pats [3], pexp [3], b2b_in [3], b2b_out [3];
    int acc, prev_acc, lat;

    r1_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    r1_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    pats[0] = {16{8'h00}}; pexp[0] = {16{8'h63}};
    pats[1] = {16{8'h53}}; pexp[1] = {16{8'hed}};
    pats[2] = {16{8'hff}}; pexp[2] = {16{8'h16}};
    b2b_in[0] = r1_in;          b2b_out[0] = r1_out;
    b2b_in[1] = {16{8'h01}};    b2b_out[1] = {16{8'h7c}};
    b2b_in[2] = {16{8'hff}};    b2b_out[2] = {16{8'h16}};
    acc = 0; prev_acc = 0; lat = 0;

    // Reset held for 3 edges
    rst_n = 1'b0; state_i = '0; valid_i = 1'b0; ready_i = 1'b0;
    for (int i = 0; i < NSW; i++) begin
      sw_state_i[i] = '0; sw_valid_i[i] = 1'b0; sw_ready_i[i] = 1'b0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_ready", ready_o, 1);
    chk("reset_valid", valid_o, 0);
    chk("reset_state", state_o, 128'h0);
    for (int i = 0; i < NSW; i++) begin
      chk($sformatf("sw%0d_reset_valid", i), sw_valid_o[i], 0);
      chk($sformatf("sw%0d_reset_state", i), sw_state_o[i], 128'h0);
    end

    // FIPS-197 App.B round 1, 4 cycles of substitution
    state_i = r1_in; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("r1_sub_ready", ready_o, 0);
    chk("r1_sub_valid", valid_o, 0);
    repeat (3) begin
      tick();
      chk("r1_early_valid", valid_o, 0);
    end
    tick();
    chk("r1_valid", valid_o, 1);
    chk("r1_state", state_o, r1_out);

    // Backpressure: hold for 10 cycles with valid_i pulses
    for (int k = 0; k < 10; k++) begin
      valid_i = (k % 2 == 0);
      state_i = {16{8'(k)}};
      tick();
      chk("bp_valid", valid_o, 1);
      chk("bp_ready", ready_o, 0);
      chk("bp_state", state_o, r1_out);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("bp_release_ready", ready_o, 1);
    chk("bp_release_valid", valid_o, 0);

    // Reset mid-SUB at cnt == 2
    state_i = r1_in; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_state", state_o, 128'h0);
    repeat (8) begin
      tick();
      chk("midrst_no_stale_valid", valid_o, 0);
    end

    // Back-to-back with valid_i held high
    ready_i = 1'b1; valid_i = 1'b1;
    for (int v = 0; v < 3; v++) begin
      state_i = b2b_in[v];
      chk($sformatf("b2b%0d_ready", v), ready_o, 1);
      tick();
      acc = cycle;
      if (v > 0) chk($sformatf("b2b%0d_spacing", v), 128'(acc - prev_acc), 128'd6);
      prev_acc = acc;
      lat = 0;
      while (!valid_o && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("b2b%0d_latency", v), 128'(lat), 128'd4);
      chk($sformatf("b2b%0d_state", v), state_o, b2b_out[v]);
      if (v == 2) valid_i = 1'b0;
      tick();
    end
    ready_i = 1'b0;
    repeat (6) begin
      chk("b2b_no_dup_valid", valid_o, 0);
      chk("b2b_idle_ready", ready_o, 1);
      tick();
    end

    // S-box corners across all BYTES_PER_CYCLE values
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NSW; i++) begin
        sw_state_i[i] = pats[p]; sw_valid_i[i] = 1'b1;
      end
      tick();
      for (int i = 0; i < NSW; i++) sw_valid_i[i] = 1'b0;
      for (int t = 1; t <= 16; t++) begin
        tick();
        for (int i = 0; i < NSW; i++) begin
          chk($sformatf("sweep_p%0d_n%0d_t%0d_valid", p, 1 << i, t),
              sw_valid_o[i], (t >= (16 >> i)) ? 128'd1 : 128'd0);
          if (t == (16 >> i))
            chk($sformatf("sweep_p%0d_n%0d_state", p, 1 << i), sw_state_o[i], pexp[p]);
        end
      end
      for (int i = 0; i < NSW; i++) sw_ready_i[i] = 1'b1;
      tick();
      for (int i = 0; i < NSW; i++) begin
        sw_ready_i[i] = 1'b0;
        chk($sformatf("sweep_p%0d_n%0d_idle", p, 1 << i), sw_ready_o[i], 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
